// File: rtl/ap_s_if.sv
// Host-side signal bundle for the ap_s associative-processor slice.
interface ap_s_if #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned ADDR_W    = 10
);
  logic [ADDR_W-1:0]      addr;
  logic [WORD_SIZE-1:0]   data;
  logic                   ap_mode;
  logic [2:0]             cmd;
  logic [1:0]             sel_col;
  logic                   sel_internal_col;
  logic                   write_en;
  logic                   read_en;
  logic [2*WORD_SIZE-1:0] data_out;
  logic                   ap_state_irq;

  modport master (
    output addr, data, ap_mode, cmd, sel_col, sel_internal_col, write_en, read_en,
    input  data_out, ap_state_irq
  );

  modport slave (
    input  addr, data, ap_mode, cmd, sel_col, sel_internal_col, write_en, read_en,
    output data_out, ap_state_irq
  );
endinterface

// File: rtl/ap_s.sv
// Associative-processor slice: columns A, B, C of CELL_QUANT cells in two banks each,
// with a bit-serial, all-cells-in-parallel compute C = f(A, B) on one latched bank.
module ap_s #(
  parameter int unsigned WORD_SIZE  = 8,
  parameter int unsigned CELL_QUANT = 512,
  parameter int unsigned ADDR_W     = 10
) (
  input logic   CLK100MHZ,
  input logic   rst,
  ap_s_if.slave bus
);
  localparam int unsigned DW    = 2 * WORD_SIZE;
  localparam int unsigned IDX_W = $clog2(CELL_QUANT);
  localparam int unsigned BIT_W = $clog2(WORD_SIZE);
  localparam int unsigned POS_W = $clog2(DW);
  localparam int unsigned CNT_W = $clog2(WORD_SIZE * WORD_SIZE);

  localparam logic [2:0] CMD_XOR  = 3'd1;
  localparam logic [2:0] CMD_AND  = 3'd2;
  localparam logic [2:0] CMD_NOT  = 3'd3;
  localparam logic [2:0] CMD_ADD  = 3'd4;
  localparam logic [2:0] CMD_SUB  = 3'd5;
  localparam logic [2:0] CMD_MULT = 3'd6;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t           state_q, state_nxt;
  logic [2:0]       cmd_q;
  logic             bank_q;
  logic [CNT_W-1:0] cnt_q;
  logic             irq_q;
  logic [DW-1:0]    dout_q;

  logic             idle, busy, start, is_mult, cnt_last, addr_ok, wr_ok, rd_ok;
  logic [IDX_W-1:0] idx;
  logic [BIT_W-1:0] row, col;
  logic [POS_W-1:0] pos;
  logic [DW-1:0]    rd_val;
  logic [DW-1:0]    c_nxt  [CELL_QUANT];
  logic             cy_nxt [CELL_QUANT];

  assign idle     = (state_q == IDLE);
  assign busy     = (state_q == COMPUTE);
  assign start    = idle && bus.ap_mode;
  assign addr_ok  = (32'(bus.addr) < CELL_QUANT);
  assign idx      = IDX_W'(bus.addr);
  assign wr_ok    = idle && bus.write_en && !bus.ap_mode && addr_ok;
  assign rd_ok    = idle && bus.read_en;
  assign is_mult  = (cmd_q == CMD_MULT);
  assign cnt_last = (cnt_q == (is_mult ? CNT_W'(WORD_SIZE * WORD_SIZE - 1) : CNT_W'(WORD_SIZE - 1)));
  // MULT walks row = multiplier bit, col = multiplicand bit; other ops only use col.
  assign row      = BIT_W'(cnt_q / CNT_W'(WORD_SIZE));
  assign col      = BIT_W'(cnt_q % CNT_W'(WORD_SIZE));
  assign pos      = POS_W'(row) + POS_W'(col);

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (bus.ap_mode) state_nxt = COMPUTE;
      COMPUTE: if (cnt_last)    state_nxt = DONE;
      DONE:    if (!bus.ap_mode) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      bank_q  <= 1'b0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_nxt;
      irq_q   <= (state_nxt == DONE);
      if (start) begin
        cmd_q  <= bus.cmd;
        bank_q <= bus.sel_internal_col;
        cnt_q  <= '0;
      end else if (busy) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (rd_ok) dout_q <= rd_val;
    end
  end

  assign bus.data_out     = dout_q;
  assign bus.ap_state_irq = irq_q;

  // Read mux; C is read before any same-cycle write lands.
  always_comb begin
    rd_val = '0;
    if (addr_ok) begin
      case (bus.sel_col)
        2'd0:    rd_val = DW'(bus.sel_internal_col ? cam_a.cell_bank1[idx] : cam_a.cell_doutb_ctrl[idx]);
        2'd1:    rd_val = DW'(bus.sel_internal_col ? cam_b.cell_bank1[idx] : cam_b.cell_doutb_ctrl[idx]);
        2'd2:    rd_val = bus.sel_internal_col ? cam_c.cell_bank1[idx] : cam_c.cell_doutb_ctrl[idx];
        default: rd_val = '0;
      endcase
    end
  end

  // One bit-step per cycle for every cell; carry/borrow kept per cell in cam_c.
  always_comb begin
    for (int unsigned i = 0; i < CELL_QUANT; i++) begin
      logic [WORD_SIZE-1:0] a_w, b_w;
      logic [DW-1:0]        cv;
      logic                 ab, bb, pp, ci, x, co;
      a_w = bank_q ? cam_a.cell_bank1[IDX_W'(i)] : cam_a.cell_doutb_ctrl[IDX_W'(i)];
      b_w = bank_q ? cam_b.cell_bank1[IDX_W'(i)] : cam_b.cell_doutb_ctrl[IDX_W'(i)];
      cv  = bank_q ? cam_c.cell_bank1[IDX_W'(i)] : cam_c.cell_doutb_ctrl[IDX_W'(i)];
      ci  = cam_c.carry[IDX_W'(i)];
      ab  = a_w[col];
      bb  = is_mult ? b_w[row] : b_w[col];
      pp  = ab & bb;
      x   = cv[pos];
      co  = 1'b0;
      case (cmd_q)
        CMD_XOR: cv[pos] = ab ^ bb;
        CMD_AND: cv[pos] = pp;
        CMD_NOT: cv[pos] = ~ab;
        CMD_ADD: begin
          cv[pos] = ab ^ bb ^ ci;
          co      = pp | (ci & (ab ^ bb));
          if (cnt_last) cv[WORD_SIZE] = co;
        end
        CMD_SUB: begin
          cv[pos] = ab ^ bb ^ ci;
          co      = (~ab & bb) | (ci & ~(ab ^ bb));
          if (cnt_last) cv[DW-1:WORD_SIZE] = {WORD_SIZE{co}};
        end
        CMD_MULT: begin
          cv[pos] = x ^ pp ^ ci;
          co      = (x & pp) | (ci & (x ^ pp));
          if (col == BIT_W'(WORD_SIZE - 1)) begin
            cv[pos + POS_W'(1)] = co;
            co                  = 1'b0;
          end
        end
        default: cv[pos] = ab | bb;
      endcase
      c_nxt[i]  = cv;
      cy_nxt[i] = co;
    end
  end

  if (1'b1) begin : cam_a
    logic [WORD_SIZE-1:0] cell_doutb_ctrl [CELL_QUANT];
    logic [WORD_SIZE-1:0] cell_bank1      [CELL_QUANT];
    always_ff @(posedge CLK100MHZ or negedge rst) begin
      if (!rst) begin
        for (int unsigned i = 0; i < CELL_QUANT; i++) begin
          cell_doutb_ctrl[IDX_W'(i)] <= '0;
          cell_bank1[IDX_W'(i)]      <= '0;
        end
      end else if (wr_ok && bus.sel_col == 2'd0) begin
        if (bus.sel_internal_col) cell_bank1[idx]      <= bus.data;
        else                      cell_doutb_ctrl[idx] <= bus.data;
      end
    end
  end

  if (1'b1) begin : cam_b
    logic [WORD_SIZE-1:0] cell_doutb_ctrl [CELL_QUANT];
    logic [WORD_SIZE-1:0] cell_bank1      [CELL_QUANT];
    always_ff @(posedge CLK100MHZ or negedge rst) begin
      if (!rst) begin
        for (int unsigned i = 0; i < CELL_QUANT; i++) begin
          cell_doutb_ctrl[IDX_W'(i)] <= '0;
          cell_bank1[IDX_W'(i)]      <= '0;
        end
      end else if (wr_ok && bus.sel_col == 2'd1) begin
        if (bus.sel_internal_col) cell_bank1[idx]      <= bus.data;
        else                      cell_doutb_ctrl[idx] <= bus.data;
      end
    end
  end

  // C is cleared in the latched bank at start so results build up from zero.
  if (1'b1) begin : cam_c
    logic [DW-1:0] cell_doutb_ctrl [CELL_QUANT];
    logic [DW-1:0] cell_bank1      [CELL_QUANT];
    logic          carry           [CELL_QUANT];
    always_ff @(posedge CLK100MHZ or negedge rst) begin
      if (!rst) begin
        for (int unsigned i = 0; i < CELL_QUANT; i++) begin
          cell_doutb_ctrl[IDX_W'(i)] <= '0;
          cell_bank1[IDX_W'(i)]      <= '0;
          carry[IDX_W'(i)]           <= 1'b0;
        end
      end else if (wr_ok && bus.sel_col == 2'd2) begin
        if (bus.sel_internal_col) cell_bank1[idx]      <= DW'(bus.data);
        else                      cell_doutb_ctrl[idx] <= DW'(bus.data);
      end else if (start) begin
        for (int unsigned i = 0; i < CELL_QUANT; i++) begin
          if (bus.sel_internal_col) cell_bank1[IDX_W'(i)]      <= '0;
          else                      cell_doutb_ctrl[IDX_W'(i)] <= '0;
          carry[IDX_W'(i)] <= 1'b0;
        end
      end else if (busy) begin
        for (int unsigned i = 0; i < CELL_QUANT; i++) begin
          if (bank_q) cell_bank1[IDX_W'(i)]      <= c_nxt[i];
          else        cell_doutb_ctrl[IDX_W'(i)] <= c_nxt[i];
          carry[IDX_W'(i)] <= cy_nxt[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_ap_s.sv
// Directed bench for ap_s: golden cell model plus a read scoreboard.
module tb_ap_s;
  localparam int unsigned W  = 8;
  localparam int unsigned N  = 512;
  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ap_s_if #(.WORD_SIZE(W), .ADDR_W(AW)) bus ();

  ap_s #(.WORD_SIZE(W), .CELL_QUANT(N), .ADDR_W(AW)) dut (
    .CLK100MHZ(clk),
    .rst      (rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;
  int ma [2][N];
  int mb [2][N];
  int mc [2][N];
  logic [15:0] sb [$];
  logic [15:0] last_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int golden(input int cmd, input int a, input int b);
    case (cmd)
      1:       return a ^ b;
      2:       return a & b;
      3:       return (~a) & 32'hff;
      4:       return a + b;
      5:       return (a - b) & 32'hffff;
      6:       return a * b;
      default: return a | b;
    endcase
  endfunction

  function automatic int model_val(input int col, input int bk, input int a);
    if (a >= int'(N)) return 0;
    case (col)
      0:       return ma[bk][a];
      1:       return mb[bk][a];
      2:       return mc[bk][a];
      default: return 0;
    endcase
  endfunction

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < int'(N); i++) begin
        ma[b][i] = 0; mb[b][i] = 0; mc[b][i] = 0;
      end
  endtask

  task automatic do_write(input int col, input int bk, input int a, input int d);
    @(negedge clk);
    bus.write_en = 1'b1; bus.read_en = 1'b0;
    bus.sel_col = 2'(col); bus.sel_internal_col = bk[0];
    bus.addr = AW'(a); bus.data = W'(d);
    @(posedge clk); #1;
    bus.write_en = 1'b0;
    if (a < int'(N)) begin
      if (col == 0) ma[bk][a] = d & 32'hff;
      if (col == 1) mb[bk][a] = d & 32'hff;
      if (col == 2) mc[bk][a] = d & 32'hff;
    end
  endtask

  task automatic read_chk(input int col, input int bk, input int a, input string tag);
    logic [15:0] e;
    sb.push_back(16'(model_val(col, bk, a)));
    @(negedge clk);
    bus.read_en = 1'b1; bus.write_en = 1'b0;
    bus.sel_col = 2'(col); bus.sel_internal_col = bk[0]; bus.addr = AW'(a);
    @(posedge clk); #1;
    bus.read_en = 1'b0;
    e = sb.pop_front();
    last_rd = e;
    chk(tag, 32'(bus.data_out), 32'(e));
  endtask

  // Start a compute, optionally poking write/read strobes that must be ignored.
  task automatic run_cmd(input int cmd, input int bk, input bit poke, input int exp_cyc);
    int n;
    bit seen;
    @(negedge clk);
    bus.cmd = 3'(cmd); bus.sel_internal_col = bk[0]; bus.ap_mode = 1'b1;
    bus.write_en = poke; bus.sel_col = 2'd0; bus.addr = AW'(5); bus.data = 8'd77;
    @(posedge clk); #1;
    bus.write_en = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      bus.cmd = 3'(~cmd);
      if (poke && n == 0) begin
        bus.write_en = 1'b1; bus.read_en = 1'b1; bus.sel_col = 2'd0;
        bus.sel_internal_col = ~bk[0]; bus.addr = AW'(2); bus.data = 8'd99;
      end else begin
        bus.write_en = 1'b0; bus.read_en = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (bus.ap_state_irq === 1'b1) seen = 1'b1;
    end
    bus.write_en = 1'b0; bus.read_en = 1'b0;
    chk($sformatf("irq_latency_cmd%0d", cmd), 32'(n), 32'(exp_cyc));
    if (poke) chk("dout_hold_in_compute", 32'(bus.data_out), 32'(last_rd));
    for (int i = 0; i < int'(N); i++) mc[bk][i] = golden(cmd, ma[bk][i], mb[bk][i]);
    @(negedge clk);
    @(posedge clk); #1;
    chk("irq_hold_done", 32'(bus.ap_state_irq), 32'd1);
    @(negedge clk);
    bus.ap_mode = 1'b0;
    @(posedge clk); #1;
    chk("irq_clear_idle", 32'(bus.ap_state_irq), 32'd0);
  endtask

  task automatic verify_c(input int bk, input string tag);
    for (int i = 0; i < int'(N); i++) read_chk(2, bk, i, tag);
  endtask

  task automatic fill(input int bk, input int maxv);
    for (int i = 0; i < int'(N); i++) begin
      do_write(0, bk, i, int'($urandom_range(0, maxv)));
      do_write(1, bk, i, int'($urandom_range(0, maxv)));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.addr = '0; bus.data = '0; bus.ap_mode = 1'b0; bus.cmd = '0;
    bus.sel_col = '0; bus.sel_internal_col = 1'b0; bus.write_en = 1'b0; bus.read_en = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_irq", 32'(bus.ap_state_irq), 32'd0);
    chk("reset_dout", 32'(bus.data_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 3; c++)
      for (int b = 0; b < 2; b++) begin
        read_chk(c, b, 0, "reset_cell0");
        read_chk(c, b, 511, "reset_cell511");
      end

    do_write(0, 0, 0, 171);
    do_write(1, 0, 0, 167);
    run_cmd(0, 0, 1'b0, 8);
    read_chk(2, 0, 0, "or_171_167");
    chk("or_model_175", 32'(mc[0][0]), 32'd175);

    do_write(0, 0, 1, 42);
    sb.push_back(16'(ma[0][1]));
    @(negedge clk);
    bus.write_en = 1'b1; bus.read_en = 1'b1; bus.sel_col = 2'd0;
    bus.sel_internal_col = 1'b0; bus.addr = AW'(1); bus.data = 8'd200;
    @(posedge clk); #1;
    bus.write_en = 1'b0; bus.read_en = 1'b0;
    last_rd = sb.pop_front();
    chk("rd_before_wr", 32'(bus.data_out), 32'(last_rd));
    ma[0][1] = 200;
    read_chk(0, 0, 1, "rd_after_wr");
    do_write(3, 0, 6, 55);
    read_chk(3, 0, 6, "rd_sel3_zero");
    do_write(0, 0, 600, 55);
    read_chk(0, 0, 600, "rd_bad_addr_zero");
    read_chk(0, 0, 88, "bad_addr_no_alias");

    fill(0, 255);
    do_write(2, 1, 7, 8'h55);
    for (int k = 0; k < 7; k++) begin
      int cmd;
      cmd = (k == 6) ? 7 : k;
      run_cmd(cmd, 0, (cmd == 4), 8);
      verify_c(0, $sformatf("c_cmd%0d", cmd));
      read_chk(0, 0, 5, "a_unchanged_start_wr");
      read_chk(0, 1, 2, "a_unchanged_compute_wr");
    end
    read_chk(2, 1, 7, "other_bank_untouched");

    do_write(0, 0, 3, 5);
    do_write(1, 0, 3, 7);
    do_write(0, 0, 4, 200);
    do_write(1, 0, 4, 100);
    run_cmd(5, 0, 1'b0, 8);
    read_chk(2, 0, 3, "sub_5_7");
    chk("sub_model_65534", 32'(mc[0][3]), 32'd65534);
    run_cmd(4, 0, 1'b0, 8);
    read_chk(2, 0, 4, "add_200_100");
    chk("add_model_300", 32'(mc[0][4]), 32'd300);

    fill(1, 15);
    do_write(0, 1, 0, 255);
    do_write(1, 1, 0, 255);
    run_cmd(6, 1, 1'b1, 64);
    verify_c(1, "c_mult");
    chk("mult_model_65025", 32'(mc[1][0]), 32'd65025);
    read_chk(2, 0, 4, "bank0_untouched_by_mult");
    read_chk(0, 1, 0, "a_unchanged_by_mult");

    @(negedge clk);
    bus.cmd = 3'd6; bus.sel_internal_col = 1'b0; bus.ap_mode = 1'b1;
    repeat (11) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_irq", 32'(bus.ap_state_irq), 32'd0);
    chk("abort_dout", 32'(bus.data_out), 32'd0);
    model_clear();
    last_rd = '0;
    @(negedge clk);
    bus.ap_mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.write_en = 1'b1; bus.sel_col = 2'd1; bus.sel_internal_col = 1'b1;
    bus.addr = AW'(9); bus.data = 8'd33;
    @(posedge clk); #1;
    bus.write_en = 1'b0;
    mb[1][9] = 33;
    chk("post_abort_irq", 32'(bus.ap_state_irq), 32'd0);
    read_chk(1, 1, 9, "first_edge_write");
    read_chk(2, 0, 0, "abort_c0_zero");
    read_chk(2, 0, 4, "abort_c4_zero");
    read_chk(2, 1, 0, "abort_c_bank1_zero");
    read_chk(0, 0, 3, "abort_a_zero");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ap_s.md
AP_S -- requirements
Module: ap_s

Interface
REQ-001 SHALL be a single-clock design; reset is asynchronous and active-low.
REQ-002 Parameter WORD_SIZE, default 8, operand width in bits.
REQ-003 Parameter CELL_QUANT, default 512, number of cells (rows) per column.
REQ-004 Parameter ADDR_W, default 10, width of addr_in.
REQ-005 CLK100MHZ  in  1  system clock; all state changes on rising edge.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 addr_in  in  ADDR_W  cell address for write/read.
REQ-008 data_in  in  WORD_SIZE  write data.
REQ-009 sel_col  in  2  column select: 0=A, 1=B, 2=C, 3=none.
REQ-010 sel_internal_col  in  1  bank select (each column holds bank 0 and bank 1).
REQ-011 write_en  in  1  write strobe; read_en  in  1  read strobe.
REQ-012 ap_mode  in  1  compute request; cmd  in  3  opcode: 0 OR, 1 XOR, 2 AND, 3 NOT, 4 ADD, 5 SUB, 6 MULT, 7 treated as OR.
REQ-013 data_out  out  2*WORD_SIZE  registered read data.
REQ-014 ap_state_irq  out  1  compute-done flag.
REQ-015 Port set SHALL match the ap_if signal bundle one-to-one (addr, data, rst, ap_mode, cmd, sel_col, sel_internal_col, clk, write_en, read_en, data_out, ap_state_irq).
REQ-016 Column storage SHALL be instances cam_a, cam_b, cam_c, each exposing array cell_doutb_ctrl[CELL_QUANT] = bank-0 cell contents (A/B: WORD_SIZE bits; C: 2*WORD_SIZE bits).

Function
REQ-017 States: IDLE, COMPUTE, DONE.
REQ-018 IDLE, write_en=1, ap_mode=0: column sel_col, bank sel_internal_col, cell addr_in <= data_in (C zero-extended); sel_col=3 or addr_in>=CELL_QUANT: no write.
REQ-019 IDLE, read_en=1: data_out <= selected cell, zero-extended, one cycle latency; invalid sel_col/addr returns 0; otherwise data_out holds.
REQ-020 Write and read same cycle: both execute; read returns pre-write value.
REQ-021 IDLE, ap_mode=1: latch cmd and sel_internal_col, enter COMPUTE; any write_en that cycle is ignored.
REQ-022 COMPUTE lasts WORD_SIZE cycles for cmd 0-5, WORD_SIZE*WORD_SIZE cycles for MULT (bit-serial over all cells in parallel); write_en/read_en ignored; cmd/ap_mode changes ignored.
REQ-023 For every cell i in latched bank: C[i] = A|B, A^B, A&B, ~A (WORD_SIZE bits), A+B (carry in bit WORD_SIZE), (A-B) mod 2^(2*WORD_SIZE), A*B full 2*WORD_SIZE product; unused upper bits zero; A and B unchanged.
REQ-024 End of COMPUTE: all C cells updated, enter DONE, ap_state_irq=1 in same edge.
REQ-025 DONE: ap_state_irq stays 1 while ap_mode=1; ap_mode=0 sampled -> IDLE, ap_state_irq=0 next edge.
REQ-026 Bank not latched remains untouched by compute.

Reset
REQ-027 rst=0 asynchronously: state IDLE, all cells of all columns and both banks = 0, data_out=0, ap_state_irq=0.
REQ-028 rst asserted during COMPUTE or DONE aborts operation; no partial result retained.
REQ-029 After rst release, first rising edge operates normally.

Verification
REQ-030 Reset, then read A/B/C cell 0 and cell 511 both banks -> data_out=0 each.
REQ-031 Write A[0]=171, B[0]=167 bank 0, cmd=0, ap_mode=1 -> irq rises 8 cycles later; C[0] low byte = 175; read C[0] -> 175.
REQ-032 Fill all 512 A/B with random 8-bit values, run each cmd 0-5 -> C[i] & 8'hff matches golden op per cell for all i.
REQ-033 Random 4-bit A/B all cells, cmd=6 -> irq after 64 cycles; C[i]=A[i]*B[i] (e.g. 15*15=225); A[0]=255,B[0]=255 -> C[0]=65025.
REQ-034 A=5,B=7,cmd=5 -> C=65534 (low byte 254); ADD 200+100 -> C=300.
REQ-035 Assert rst mid-COMPUTE -> irq=0, C cells 0; write during COMPUTE -> cell unchanged; hold ap_mode high in DONE -> irq held, drop -> irq 0, IDLE.
